// File: rtl/shift_seq.sv
// Multi-cycle barrel-less shifter: one bit per clock, SLL/SRL/SRA, with
// flush abort and a result register that only changes on completion.
module shift_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        flush,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [4:0]  shamt,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] res
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] data_q, data_nxt;
   logic [31:0] shifted;
   logic [31:0] res_q, res_nxt;
   logic [4:0]  cnt_q, cnt_nxt;
   logic [1:0]  op_q, op_nxt;
   logic        sign_q, sign_nxt;

   // Single-bit step of the latched operation; code 11 behaves as SRL.
   always_comb begin
      shifted = {1'b0, data_q[31:1]};
      case (op_q)
         2'b00:   shifted = {data_q[30:0], 1'b0};
         2'b10:   shifted = {sign_q, data_q[31:1]};
         default: shifted = {1'b0, data_q[31:1]};
      endcase
   end

   always_comb begin
      state_nxt = state;
      data_nxt  = data_q;
      cnt_nxt   = cnt_q;
      op_nxt    = op_q;
      sign_nxt  = sign_q;
      res_nxt   = res_q;

      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  data_nxt = A;
                  op_nxt   = op;
                  sign_nxt = A[31];
                  cnt_nxt  = shamt;
                  if (shamt == 5'd0) begin
                     state_nxt = DONE;
                     res_nxt   = A;
                  end else begin
                     state_nxt = SHIFT;
                  end
               end
            end
            // res is loaded on the edge entering DONE so it is valid alongside done.
            SHIFT: begin
               data_nxt = shifted;
               if (cnt_q <= 5'd1) begin
                  cnt_nxt   = '0;
                  state_nxt = DONE;
                  res_nxt   = shifted;
               end else begin
                  cnt_nxt = cnt_q - 5'd1;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         data_q <= '0;
         cnt_q  <= '0;
         op_q   <= '0;
         sign_q <= 1'b0;
         res_q  <= '0;
      end else begin
         state  <= state_nxt;
         data_q <= data_nxt;
         cnt_q  <= cnt_nxt;
         op_q   <= op_nxt;
         sign_q <= sign_nxt;
         res_q  <= res_nxt;
      end
   end

   assign ready = (state == IDLE);
   assign busy  = (state == SHIFT) || (state == DONE);
   assign done  = (state == DONE);
   assign res   = res_q;

endmodule

// File: tb/tb_shift_seq.sv
// Testbench for shift_seq: directed vector table, random operations against an
// arithmetic shift model, and hand-written flush/reset/busy-start sequences.
module tb_shift_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] A = 32'h0;
   logic [4:0]  shamt = 5'd0;
   logic        ready, busy, done;
   logic [31:0] res;

   int          checks = 0;
   int          passes = 0;
   logic [31:0] lastRes = 32'h0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [4:0]  s;
      logic [31:0] expRes;
   } vec_t;

   vec_t vecs[8];

   shift_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .flush (flush),
      .op    (op),
      .A     (A),
      .shamt (shamt),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .res   (res)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] a, input int s);
      logic signed [31:0] sa;
      sa = a;
      case (o)
         2'b00:   return a << s;
         2'b10:   return sa >>> s;
         default: return a >> s;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic watchNoDone(input string name, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin
         tick();
         if (done) cnt++;
      end
      checkOutput(name, cnt, 0);
   endtask

   // Called at a negedge; pokeAt >= 0 pulses a second start while the first is running.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                                input logic [31:0] expRes, input int pokeAt);
      int k;
      bit seen;
      start = 1'b1;
      op    = o;
      A     = a;
      shamt = s;
      tick();
      start = 1'b0;
      A     = $urandom;
      op    = 2'($urandom);
      shamt = 5'($urandom);
      seen  = 1'b0;
      k     = 0;
      while (!seen && k <= 40) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            start = (k == pokeAt);
            if (start) begin
               A     = $urandom;
               op    = 2'($urandom);
               shamt = 5'($urandom);
            end
            tick();
            start = 1'b0;
            k++;
         end
      end
      checkOutput("latency", seen ? 32'(k) : 32'hFFFF_FFFF, 32'(s));
      checkOutput("res", res, expRes);
      tick();
      checkOutput("ready after done", {29'b0, ready, busy, done}, 32'b100);
      lastRes = expRes;
      if (pokeAt >= 0) watchNoDone("single done", 12);
   endtask

   initial begin
      vecs[0] = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
      vecs[1] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
      vecs[2] = '{2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001};
      vecs[3] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
      vecs[4] = '{2'b11, 32'hF000_0000, 5'd4,  32'h0F00_0000};
      vecs[5] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
      vecs[6] = '{2'b10, 32'h8000_F000, 5'd8,  32'hFF80_00F0};
      vecs[7] = '{2'b00, 32'h0000_ABCD, 5'd16, 32'hABCD_0000};

      // Reset must win over start and flush.
      rst_n = 1'b0;
      start = 1'b1;
      flush = 1'b1;
      A     = 32'hFFFF_FFFF;
      repeat (2) tick();
      checkOutput("reset flags", {29'b0, ready, busy, done}, 32'b100);
      checkOutput("reset res", res, 32'h0);
      rst_n = 1'b1;
      start = 1'b0;
      flush = 1'b0;

      // First vector starts on the very first edge out of reset.
      for (int i = 0; i < 8; i++)
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].s, vecs[i].expRes, -1);

      // A start while busy must be dropped, not queued.
      applyStimulus(2'b01, 32'h1234_5678, 5'd8, 32'h0012_3456, 3);

      // Flush mid-shift: back to IDLE, res untouched, no done.
      start = 1'b1;
      op    = 2'b01;
      A     = 32'hDEAD_BEEF;
      shamt = 5'd10;
      tick();
      start = 1'b0;
      repeat (3) tick();
      checkOutput("busy before flush", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush flags", {29'b0, ready, busy, done}, 32'b100);
      checkOutput("flush res", res, lastRes);
      watchNoDone("no done after flush", 15);

      // Flush and start together in IDLE: nothing accepted.
      start = 1'b1;
      flush = 1'b1;
      op    = 2'b00;
      A     = 32'h0000_0055;
      shamt = 5'd0;
      tick();
      start = 1'b0;
      flush = 1'b0;
      checkOutput("flush+start flags", {29'b0, ready, busy, done}, 32'b100);
      checkOutput("flush+start res", res, lastRes);
      watchNoDone("no done flush+start", 5);

      // Reset in the middle of a shift.
      start = 1'b1;
      op    = 2'b10;
      A     = 32'hFFFF_0000;
      shamt = 5'd20;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("mid reset flags", {29'b0, ready, busy, done}, 32'b100);
      checkOutput("mid reset res", res, 32'h0);
      lastRes = 32'h0;
      watchNoDone("no done after reset", 25);

      // Random operations against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         logic [1:0]  ro;
         logic [31:0] ra;
         logic [4:0]  rs;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rs = 5'($urandom_range(0, 31));
         applyStimulus(ro, ra, rs, refShift(ro, ra, int'(rs)), -1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
